// File: rtl/analog_switch_seq.sv
// -----------------------------------------------------------------------------
// analog_switch_seq
//
// Break-before-make sequencer for the analog switch matrix gate enables.
// A requested switch mask is taken over a valid/ready handshake and applied so
// that switches being opened always drop at least DEAD_CYCLES clocks before any
// newly selected switch closes.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   ena        in   design enable; low forces every switch open
//   sel_valid  in   request valid
//   sel        in   requested mask, bit i set = switch i closed
//   sel_ready  out  request can be accepted (combinational)
//   sw_en      out  registered gate enables to the switch macro
//   busy       out  dead-time sequence in progress
//   done       out  one-cycle pulse when sw_en reaches the target
//   err        out  one-cycle pulse when an illegal request is rejected
// -----------------------------------------------------------------------------
module analog_switch_seq #(
   parameter int N_SW        = 6,
   parameter int DEAD_CYCLES = 4,
   parameter bit EXCLUSIVE   = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            sel_valid,
   input  logic [N_SW-1:0] sel,
   output logic            sel_ready,
   output logic [N_SW-1:0] sw_en,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
   localparam int POP_W = $clog2(N_SW + 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_DEAD = 1'b1;

   logic             state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [N_SW-1:0]  target_q, target_d;
   logic [N_SW-1:0]  sw_en_q,  sw_en_d;
   logic             done_q,   done_d;
   logic             err_q,    err_d;

   logic            accept;
   logic            illegal;
   logic [N_SW-1:0] to_open;
   logic [N_SW-1:0] to_close;

   // Number of set bits in a mask; an N_SW-input sum cannot overflow POP_W.
   function automatic logic [POP_W-1:0] popcount(input logic [N_SW-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < N_SW; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

   assign sel_ready = rst_n && ena && (state_q == ST_IDLE);
   assign accept    = sel_valid && sel_ready;
   assign illegal   = EXCLUSIVE && (popcount(sel) > POP_W'(1));
   assign to_open   = sw_en_q & ~sel;
   assign to_close  = sel & ~sw_en_q;

   // NOTE: every next-state signal gets a default before any branch, so no
   // path through this block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      sw_en_d  = sw_en_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      if (!ena) begin
         // Abandon anything in flight; nothing resumes when ena returns.
         state_d = ST_IDLE;
         cnt_d   = '0;
         sw_en_d = '0;
      end else if (state_q == ST_DEAD) begin
         if (cnt_q == CNT_W'(1)) begin
            sw_en_d = target_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (accept) begin
         target_d = sel;
         if (illegal) begin
            err_d = 1'b1;
         end else if (sel == sw_en_q) begin
            done_d = 1'b1;
         end else if ((to_open != '0) && (to_close != '0)) begin
            // Break now, make after the dead time.
            sw_en_d = sw_en_q & sel;
            state_d = ST_DEAD;
            cnt_d   = CNT_W'(DEAD_CYCLES);
         end else begin
            // Pure make or pure break: no switch changes in the opposite
            // direction, so the new mask can be applied at once.
            sw_en_d = sel;
            done_d  = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         sw_en_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         sw_en_q  <= sw_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign sw_en = sw_en_q;
   assign busy  = (state_q == ST_DEAD);
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_analog_switch_seq.sv
// -----------------------------------------------------------------------------
// tb_analog_switch_seq
//
// Drives two sequencers from the same stimulus: one with EXCLUSIVE = 1, one
// with EXCLUSIVE = 0. A transaction-level reference model tracks, per
// instance, the visible switch mask and the absolute clock edge at which a
// pending break-and-make completes.
// -----------------------------------------------------------------------------
module tb_analog_switch_seq;

   localparam int N_SW = 6;
   localparam int DEAD = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ena;
   logic            sel_valid;
   logic [N_SW-1:0] sel;

   logic            ready_x, busy_x, done_x, err_x;
   logic [N_SW-1:0] sw_x;
   logic            ready_n, busy_n, done_n, err_n;
   logic [N_SW-1:0] sw_n;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   // Reference model state, index 0 = exclusive instance, 1 = non-exclusive.
   logic [N_SW-1:0] m_sw   [2];
   logic [N_SW-1:0] m_tgt  [2];
   logic            m_busy [2];
   logic            m_done [2];
   logic            m_err  [2];
   int              m_final[2];
   bit              m_excl [2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   analog_switch_seq #(.N_SW(N_SW), .DEAD_CYCLES(DEAD), .EXCLUSIVE(1'b1)) dut_x (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sel_valid(sel_valid), .sel(sel),
      .sel_ready(ready_x), .sw_en(sw_x), .busy(busy_x), .done(done_x), .err(err_x)
   );

   analog_switch_seq #(.N_SW(N_SW), .DEAD_CYCLES(DEAD), .EXCLUSIVE(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sel_valid(sel_valid), .sel(sel),
      .sel_ready(ready_n), .sw_en(sw_n), .busy(busy_n), .done(done_n), .err(err_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
      end
   endtask

   function automatic logic [N_SW-1:0] dut_sw(input int i);
      return (i == 0) ? sw_x : sw_n;
   endfunction

   // Advance the model across one clock edge with the given inputs.
   task automatic model_edge(input int i, input logic r, input logic e,
                             input logic v, input logic [N_SW-1:0] s, input int at_edge);
      m_done[i] = 1'b0;
      m_err[i]  = 1'b0;
      if (!r || !e) begin
         m_sw[i]   = '0;
         m_busy[i] = 1'b0;
         if (!r) m_tgt[i] = '0;
      end else if (m_busy[i]) begin
         if (at_edge == m_final[i]) begin
            m_sw[i]   = m_tgt[i];
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
         end
      end else if (v) begin
         m_tgt[i] = s;
         if (m_excl[i] && ($countones(s) > 1)) begin
            m_err[i] = 1'b1;
         end else if (s == m_sw[i]) begin
            m_done[i] = 1'b1;
         end else if (((m_sw[i] & ~s) != '0) && ((s & ~m_sw[i]) != '0)) begin
            m_sw[i]    = m_sw[i] & s;
            m_busy[i]  = 1'b1;
            m_final[i] = at_edge + DEAD;
         end else begin
            m_sw[i]   = s;
            m_done[i] = 1'b1;
         end
      end
   endtask

   // One clock cycle: apply inputs at the falling edge, check the handshake,
   // step the model, then compare registered outputs at the next falling edge.
   task automatic step(input logic r, input logic e, input logic v, input logic [N_SW-1:0] s);
      logic [N_SW-1:0] old_sw [2];
      logic [N_SW-1:0] new_sw;
      rst_n     = r;
      ena       = e;
      sel_valid = v;
      sel       = s;
      #1;
      check("ready_x", ready_x, r && e && !m_busy[0]);
      check("ready_n", ready_n, r && e && !m_busy[1]);
      for (int i = 0; i < 2; i++) begin
         old_sw[i] = dut_sw(i);
         model_edge(i, r, e, v, s, edge_n + 1);
      end
      @(negedge clk);
      edge_n++;
      check("sw_x",   sw_x,   m_sw[0]);
      check("busy_x", busy_x, m_busy[0]);
      check("done_x", done_x, m_done[0]);
      check("err_x",  err_x,  m_err[0]);
      check("sw_n",   sw_n,   m_sw[1]);
      check("busy_n", busy_n, m_busy[1]);
      check("done_n", done_n, m_done[1]);
      check("err_n",  err_n,  m_err[1]);
      for (int i = 0; i < 2; i++) begin
         new_sw = dut_sw(i);
         // A switch may never close in the same edge that another one opens.
         check("bbm", ((new_sw & ~old_sw[i]) != '0) && ((old_sw[i] & ~new_sw) != '0), 1'b0);
      end
   endtask

   initial begin
      logic            r, e, v;
      logic [N_SW-1:0] s;

      for (int i = 0; i < 2; i++) begin
         m_sw[i] = '0; m_tgt[i] = '0; m_busy[i] = 1'b0;
         m_done[i] = 1'b0; m_err[i] = 1'b0; m_final[i] = 0;
      end
      rst_n = 1'b0; ena = 1'b1; sel_valid = 1'b1; sel = 6'b000100;
      @(negedge clk);

      // Reset held with a pending request.
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 6'b000100);
      check("rst_sw", sw_x, 6'b000000);
      check("rst_busy", busy_x, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000000);
      check("rel_ready", ready_x, 1'b1);

      // Make-only.
      step(1'b1, 1'b1, 1'b1, 6'b000100);
      check("mk_sw", sw_x, 6'b000100);
      check("mk_done", done_x, 1'b1);
      check("mk_busy", busy_x, 1'b0);

      // Break-only then make-only to reach 000001.
      step(1'b1, 1'b1, 1'b1, 6'b000000);
      check("brk_sw", sw_x, 6'b000000);
      step(1'b1, 1'b1, 1'b1, 6'b000001);

      // Break-and-make 000001 -> 000010.
      step(1'b1, 1'b1, 1'b1, 6'b000010);
      for (int k = 1; k <= DEAD; k++) begin
         check("bm_dead_sw", sw_x, 6'b000000);
         check("bm_dead_busy", busy_x, 1'b1);
         step(1'b1, 1'b1, 1'b0, 6'b000000);
      end
      check("bm_final_sw", sw_x, 6'b000010);
      check("bm_final_done", done_x, 1'b1);

      // Two bits set: rejected when exclusive, applied otherwise.
      step(1'b1, 1'b1, 1'b1, 6'b000011);
      check("ill_err", err_x, 1'b1);
      check("ill_sw", sw_x, 6'b000010);
      check("ill_done", done_x, 1'b0);
      check("nx_sw", sw_n, 6'b000011);

      // Abort a break-and-make 000001 -> 100000 by dropping ena.
      step(1'b1, 1'b1, 1'b1, 6'b000000);
      step(1'b1, 1'b1, 1'b1, 6'b000001);
      step(1'b1, 1'b1, 1'b1, 6'b100000);
      step(1'b1, 1'b1, 1'b0, 6'b100000);
      step(1'b1, 1'b0, 1'b0, 6'b100000);
      check("ab_sw", sw_x, 6'b000000);
      check("ab_busy", busy_x, 1'b0);
      check("ab_done", done_x, 1'b0);
      for (int k = 0; k < DEAD + 2; k++) step(1'b1, 1'b1, 1'b0, 6'b100000);
      check("ab_ready", ready_x, 1'b1);
      check("ab_hold_sw", sw_x, 6'b000000);

      // Random stress with enable and reset glitches.
      s = 6'b000000;
      for (int k = 0; k < 10000; k++) begin
         r = ($urandom_range(0, 299) != 0);
         e = ($urandom_range(0, 59) != 0);
         v = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: s = N_SW'(1) << $urandom_range(0, N_SW - 1);
            1: s = '0;
            2: s = N_SW'($urandom);
            default: ;
         endcase
         step(r, e, v, s);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/analog_switch_seq.md
# analog_switch_seq

Digital sequencer that drives the gate-enable lines of the analog switch matrix routing the `ua[5:0]` pads. It accepts a requested switch mask over a valid/ready handshake and applies it with break-before-make ordering: switches being opened drop first, a programmable dead time elapses, then the new switches close. It sits directly upstream of the analog switch macro, between the command decoder fed from `ui_in`/`uio_in` and the switch gate drivers.

## Interface

Parameters:
- `N_SW`, 6: number of switches, one enable bit each.
- `DEAD_CYCLES`, 4: dead-time length in `clk` cycles; legal range 1..255.
- `EXCLUSIVE`, 1: when 1, a request with more than one bit set is illegal.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst_n`  input  1  reset; synchronous and active-low.
- `ena`  input  1  design enable; low forces all switches open.
- `sel_valid`  input  1  request valid.
- `sel`  input  N_SW  requested switch mask; bit i set means switch i closed.
- `sel_ready`  output  1  request can be accepted.
- `sw_en`  output  N_SW  registered gate enables to the switch macro.
- `busy`  output  1  sequence in progress.
- `done`  output  1  one-cycle pulse when `sw_en` reaches the target.
- `err`  output  1  one-cycle pulse when an illegal request is rejected.

## Operation

- States: IDLE, DEAD.
- `sel_ready` = `rst_n` && `ena` && (state == IDLE). It is combinational from the state.
- An accept occurs in cycle t when `sel_valid` && `sel_ready`. `sel` is latched into `target`.
- Illegal request (`EXCLUSIVE` = 1 and popcount(`sel`) > 1):
  - `err` = 1 at t+1.
  - `sw_en` is unchanged and the state stays IDLE.
  - No `done` pulse.
- `sel` == `sw_en`: `done` = 1 at t+1; no other change.
- Make-only (`sel` & ~`sw_en` != 0, `sw_en` & ~`sel` == 0) or break-only (only bits to clear):
  - `sw_en` = `sel` at t+1.
  - `done` = 1 at t+1.
  - The state stays IDLE.
- Break-and-make (bits both to clear and to set):
  - At t+1: `sw_en` = old `sw_en` & `sel`; state = DEAD; `cnt` = `DEAD_CYCLES`.
  - In DEAD: `cnt` decrements every cycle. When `cnt` == 1 the next edge sets `sw_en` = `target`, pulses `done`, and returns to IDLE.
  - Final `sw_en` appears at t+1+`DEAD_CYCLES`.
- `busy` = (state == DEAD). It is registered along with the state.
- `sel_valid` while not ready is ignored. A requester holds `sel` stable until accepted. `target` is not re-sampled during DEAD.
- `ena` low in any cycle:
  - Next edge: `sw_en` = 0, state = IDLE, `cnt` = 0, `busy` = 0.
  - No `done`/`err` pulse.
  - A sequence in flight is abandoned and is not resumed when `ena` returns.
- Reset (`rst_n` = 0 at an edge): `sw_en` = 0, state = IDLE, `cnt` = 0, `busy` = 0, `done` = 0, `err` = 0. Reset mid-DEAD abandons the sequence.
- Width rules:
  - `cnt` width = $clog2(`DEAD_CYCLES`+1).
  - Popcount is an `N_SW`-input sum compared against 1; no overflow is possible.
- Invariant: no switch that was open before an accept and is closed after it is ever closed in the same cycle as any switch being opened.

## Timing

- Outputs `sw_en`, `busy`, `done` and `err` are registers. `sel_ready` is combinational from the state, `ena` and `rst_n`.
- Accept-to-final latency: 1 cycle (no-op, make-only, break-only, illegal) or `DEAD_CYCLES`+1 cycles (break-and-make).
- Throughput:
  - Back-to-back accepts are allowed every cycle while in IDLE.
  - After a break-and-make, the earliest next accept is the cycle `done` is high, since `sel_ready` = 1 in that cycle.
- `done` and `err` are never high in the same cycle and are never high for two consecutive cycles from one accept.

## Test plan

- Reset/default: hold `rst_n` = 0 for 3 cycles with `sel_valid` = 1 -> `sw_en` = 0, `sel_ready` = 0, `busy` = 0, no pulses. Release -> `sel_ready` = 1 next cycle.
- Make-only: from `sw_en` = 000000, accept `sel` = 000100 at t -> `sw_en` = 000100 and `done` = 1 at t+1, `busy` never high.
- Break-and-make, `DEAD_CYCLES` = 4: from 000001, accept 000010 at t -> `sw_en` = 000000 at t+1..t+4, `busy` = 1 at t+1..t+4, `sw_en` = 000010 and `done` = 1 at t+5, `sel_ready` = 0 at t+1..t+4.
- Illegal: `EXCLUSIVE` = 1, `sw_en` = 000010, accept 000011 -> `err` = 1 next cycle, `sw_en` stays 000010, no `done`. Repeat with `EXCLUSIVE` = 0: the sequence runs and ends with `sw_en` = 000011.
- Abort: start break-and-make 000001 -> 100000, drop `ena` at t+2 -> `sw_en` = 0 and `busy` = 0 at t+3, no `done`. Raise `ena` -> `sel_ready` = 1 and `sw_en` stays 0 until a new accept.
- Random stress: 10k random requests with random `ena`/`rst_n` glitches. A scoreboard checks the break-before-make invariant, the latency rules, and one `done` or `err` pulse per accept.
